// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Adds synchronous flush, an occupancy output and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int DATA_W         = 64,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    // Valid/ready: a beat moves on an edge where valid and ready are both 1;
    // valid never depends on ready, and ready is a register (no comb path upstream).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   main_q;
    logic [DATA_W-1:0]   skid_q;
    logic                in_ready_q;
    logic [CNT_W-1:0]    stall_q;
    logic                in_fire;
    logic                out_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q <= ONE;
                        main_q  <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat behind the main entry.
                        state_q    <= TWO;
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_q    <= ONE;
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (stall_clr) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two builds (clear-on-flush / hold-on-flush with a
// 3-bit stall counter) share one stimulus stream and one FIFO scoreboard.
module tb_pipe_stage_skid;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         stall_clr = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [W-1:0] out_data_a, out_data_b;
    logic [1:0]   occ_a, occ_b;
    logic [15:0]  stall_a;
    logic [2:0]   stall_b;

    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset block
    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .occupancy(occ_a), .stall_cnt(stall_a), .stall_clr(stall_clr)
    );

    pipe_stage_skid #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b0), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .occupancy(occ_b), .stall_cnt(stall_b), .stall_clr(stall_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs, return just after the edge
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        stall_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic ov, input logic [W-1:0] da,
                                 input logic [W-1:0] db, input logic ir, input logic [1:0] oc);
        check({tag, "_out_valid"}, out_valid_a, ov);
        check({tag, "_out_data_a"}, out_data_a, da);
        check({tag, "_out_data_b"}, out_data_b, db);
        check({tag, "_in_ready"}, in_ready_a, ir);
        check({tag, "_occupancy"}, occ_a, oc);
    endtask

    // scoreboard: exp_q holds accepted beats still owned by the stage
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] prev_data;
    logic [W-1:0] popped;
    int           stall_true = 0;
    bit           model_ok = 1'b0;
    bit           prev_hold = 1'b0;

    always @(negedge clk) begin
        bit in_rdy_m;
        bit out_v_m;
        if (model_ok) begin
            check("occupancy_a", occ_a, exp_q.size());
            check("occupancy_b", occ_b, exp_q.size());
            check("out_valid_a", out_valid_a, exp_q.size() > 0);
            check("out_valid_b", out_valid_b, exp_q.size() > 0);
            check("in_ready_a", in_ready_a, exp_q.size() < 2);
            check("in_ready_b", in_ready_b, exp_q.size() < 2);
            check("data_a", out_data_a, m_a);
            check("data_b", out_data_b, m_b);
            check("stall_a", stall_a, (stall_true > 65535) ? 65535 : stall_true);
            check("stall_b", stall_b, (stall_true > 7) ? 7 : stall_true);
            if (prev_hold) check("stable", out_data_a, prev_data);
        end
        prev_hold = model_ok && rst && !flush && (exp_q.size() > 0) && !out_ready;
        prev_data = out_data_a;
        if (!rst) begin
            exp_q.delete();
            stall_true = 0;
            m_a = '0;
            m_b = '0;
        end else begin
            in_rdy_m = exp_q.size() < 2;
            out_v_m  = exp_q.size() > 0;
            if (stall_clr) stall_true = 0;
            else if (out_v_m && !out_ready) stall_true++;
            if (out_v_m && out_ready) begin
                popped = exp_q.pop_front();
                check("delivered_a", out_data_a, popped);
                check("delivered_b", out_data_b, popped);
            end
            if (flush) begin
                exp_q.delete();
                m_a = '0;
            end else if (in_valid && in_rdy_m) begin
                exp_q.push_back(in_data);
            end
            if (exp_q.size() > 0) begin
                m_a = exp_q[0];
                m_b = exp_q[0];
            end
        end
        model_ok = 1'b1;
    end

    logic [W-1:0] pt [4] = '{16'h11, 16'h22, 16'h33, 16'h44};

    initial begin
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        check_outputs("reset", 1'b0, '0, '0, 1'b1, 2'd0);
        check("reset_stall", stall_a, 0);

        // pass-through at full rate
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, pt[i], 1'b1, 1'b0, 1'b0);
            check_outputs("pass", 1'b1, pt[i], pt[i], 1'b1, 2'd1);
            check("pass_stall", stall_a, 0);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("drain_occ", occ_a, 0);

        // backpressure fill then drain
        cycle(1'b1, 16'hA, 1'b0, 1'b0, 1'b0);
        check_outputs("fill1", 1'b1, 16'hA, 16'hA, 1'b1, 2'd1);
        cycle(1'b1, 16'hB, 1'b0, 1'b0, 1'b0);
        check_outputs("fill2", 1'b1, 16'hA, 16'hA, 1'b0, 2'd2);
        check("fill2_stall", stall_a, 1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("hold_stall", stall_a, 2);
        check("hold_data", out_data_a, 16'hA);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_outputs("pop1", 1'b1, 16'hB, 16'hB, 1'b1, 2'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("pop2_valid", out_valid_a, 1'b0);
        check("pop2_occ", occ_a, 0);

        // flush while two entries are held, with a concurrent input
        cycle(1'b1, 16'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'hB, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'hC, 1'b0, 1'b1, 1'b0);
        check_outputs("flush", 1'b0, 16'h0, 16'hA, 1'b1, 2'd0);
        check("flush_stall", stall_a, 4);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_outputs("post_flush", 1'b0, 16'h0, 16'hA, 1'b1, 2'd0);

        // stall counter saturation on the 3-bit build
        cycle(1'b1, 16'h5, 1'b0, 1'b0, 1'b1);
        check("clr_stall", stall_a, 0);
        repeat (10) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("sat_stall_a", stall_a, 10);
        check("sat_stall_b", stall_b, 7);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_prio_a", stall_a, 0);
        check("clr_prio_b", stall_b, 0);

        // reset mid-operation with concurrent input and flush
        cycle(1'b1, 16'h6, 1'b0, 1'b0, 1'b0);
        check("pre_rst_occ", occ_a, 2);
        rst = 1'b0;
        cycle(1'b1, 16'h77, 1'b0, 1'b1, 1'b0);
        check_outputs("mid_rst", 1'b0, '0, '0, 1'b1, 2'd0);
        check("mid_rst_stall_b", stall_b, 0);
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("after_rst_valid", out_valid_a, 1'b0);

        // random soak
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0));
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic parametrised pipeline stage register; the successor to the fixed-field stage latches between EXE/MEM/WB.
- Payload is one packed bus of DATA_W bits carrying control, result, store data and destination register, as the instantiating stage defines.
- Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush, occupancy output and a saturating stall-cycle counter.
- With the skid buffer, stalls do not need a combinational ready path back up the pipeline, and back-to-back transfers sustain full throughput.

Parameters:
- DATA_W, 64, payload width in bits (must be >= 1).
- CLEAR_ON_FLUSH, 1: 1 = payload registers are zeroed on flush; 0 = payload registers hold their contents (only valid is cleared).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous kill of all held entries and of the current input.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept; a registered output.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to downstream; driven directly from the main register.
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturating.
- stall_clr  in  1  synchronously zeroes stall_cnt.

Behaviour:
- Storage:
  - Main register M, drives out_data and out_valid.
  - Skid register S.
  - State EMPTY(0) / ONE(1) / TWO(2); occupancy equals the state encoding.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (state != TWO), registered.
  - out_valid = (state != EMPTY).
- Reset (rst=0 at an edge):
  - state=EMPTY; out_valid=0; out_data=0; S=0; in_ready=1; occupancy=0; stall_cnt=0.
  - Inputs are ignored while rst=0.
- Priority: reset > flush > normal operation.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, M<=in_data. Otherwise stay.
  - ONE:
    - in_fire & out_fire -> ONE, M<=in_data.
    - in_fire & !out_fire -> TWO, S<=in_data.
    - !in_fire & out_fire -> EMPTY.
    - Neither -> ONE, M holds.
  - TWO: in_fire cannot occur. out_fire -> ONE, M<=S. Otherwise stay.
- Latency:
  - 1 cycle from in_fire in EMPTY to out_valid=1 with the new data.
  - In steady flow (out_ready=1), one transfer per cycle, and the state stays ONE.
- Ordering: strictly FIFO. The skid entry always leaves after the main entry.
- Stability: while out_valid=1 and out_ready=0, out_data must not change.
- Flush (flush=1 at an edge, rst=1):
  - state->EMPTY; the concurrent in_data is discarded even if in_fire.
  - An out_fire in the same cycle counts as delivered; downstream owns it.
  - Next cycle: out_valid=0, in_ready=1, occupancy=0.
  - If CLEAR_ON_FLUSH=1: M and S are zeroed. If 0: M and S hold their contents.
- Stall counter:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - stall_clr has priority over increment: the result is 0.
  - Not affected by flush; cleared only by reset or stall_clr.
- Width rules:
  - Payload is copied bit-exact; no arithmetic on data.
  - occupancy is 2 bits. State encoding 3 is unreachable; if entered, it is treated as EMPTY on the next edge.

Test Plan:
- Reset then pass-through: after reset, in_valid=1 for 4 consecutive cycles with data 0x11, 0x22, 0x33, 0x44 and out_ready=1 -> out_data shows 0x11..0x44 on cycles 1..4 with out_valid=1; in_ready stays 1; occupancy=1; stall_cnt=0.
- Backpressure fill: out_ready=0, push 0xA then 0xB -> occupancy 1 then 2; in_ready=0 after the second push; out_data holds 0xA; stall_cnt increments each cycle. Then out_ready=1 -> 0xA then 0xB delivered; occupancy goes 2 -> 1 -> 0; in_ready returns to 1 one cycle after the first pop.
- Flush in TWO, in both CLEAR_ON_FLUSH builds: with entries 0xA and 0xB held, flush=1 for one cycle with in_valid=1 and in_data=0xC -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xC never appears at the output.
  - CLEAR_ON_FLUSH=1: out_data=0.
  - CLEAR_ON_FLUSH=0: out_data=0xA.
- Stall counter saturation: build with CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt reaches 7 and holds at 7. Assert stall_clr together with a stall cycle -> stall_cnt=0.
- Reset mid-operation: with occupancy=2, drive rst=0 for one edge -> all outputs equal their reset values. A concurrent in_valid or flush has no effect.
- Random soak: randomised in_valid, out_ready and occasional flush for 10k cycles against a FIFO scoreboard -> no loss, duplication or reordering of accepted items, except items discarded by flush. out_data is stable whenever out_valid=1 and out_ready=0.
